mux_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one pipelined 256:1 bit-select mux (Mux_256x1 tree) among NREQ requesters.
- Each requester presents an 8-bit bit index. The arbiter grants one requester per cycle, drives the mux select, and tracks the request through the mux latency.
- Returns the selected bit tagged with the requester ID.
- Sits between the bit-fetch clients and the mux tree; it is the only driver of the mux select.

---
 rtl/mux_rr_arbiter.sv | 133 +++++++++++++
 tb/tb_mux_rr_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
//   Round-robin arbiter in front of a shared, optionally pipelined 256:1 bit-select mux.
//   Each cycle one requester is granted. Its bit index is registered onto mux_sel, and a
//   {valid, id} tag follows the request through the mux latency. The selected bit comes
//   back on rsp_data, tagged with rsp_id.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req        per-requester request, held until granted
//   req_sel    packed bit index per requester, requester k at [k*SEL_W +: SEL_W]
//   gnt        one-hot combinational grant; accepted at the rising edge where it is high
//   mux_sel    registered select to the mux tree
//   mux_out    mux tree output
//   rsp_valid  registered response strobe
//   rsp_id     owner of the response (holds while rsp_valid=0)
//   rsp_data   selected bit (holds while rsp_valid=0)
//   idle       no request pending and no tag in flight
//
// Build option
//   MUX_ARB_PRIO0_EN  defined: requester 0 has fixed top priority and does not move the
//                     round-robin pointer. Undefined: pure round-robin over all requesters.

module mux_rr_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned SEL_W   = 8,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned MUX_LAT = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*SEL_W-1:0]   req_sel,
  output logic [NREQ-1:0]         gnt,
  output logic [SEL_W-1:0]        mux_sel,
  input  logic                    mux_out,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    rsp_data,
  output logic                    idle
);

  // One tag stage per mux register stage, plus one for the select register itself.
  localparam int unsigned NStg = MUX_LAT + 1;
  localparam int unsigned TagW = NStg * ID_W;

  logic [ID_W-1:0]  ptr_q, ptr_d, ptr_nxt;
  logic [SEL_W-1:0] mux_sel_q, mux_sel_d;
  logic [NStg-1:0]  tag_vld_q, tag_vld_d;
  logic [TagW-1:0]  tag_id_q, tag_id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic             rsp_data_q, rsp_data_d;

  logic             gnt_vld;
  logic [ID_W-1:0]  gnt_id;
  logic [ID_W-1:0]  idx;

  // Arbitration: scan from ptr upward with wrap; the first requester found wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    idx     = '0;
`ifdef MUX_ARB_PRIO0_EN
    // Requester 0 pre-empts the scan; gnt_id stays 0.
    if (req[0]) gnt_vld = 1'b1;
`endif
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = ID_W'((32'(ptr_q) + i) % NREQ);
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = idx;
      end
    end
    gnt = '0;
    if (gnt_vld && rst_n) gnt[gnt_id] = 1'b1;
  end

  always_comb begin
    ptr_nxt = (32'(gnt_id) == NREQ - 1) ? '0 : gnt_id + 1'b1;

    ptr_d     = ptr_q;
    mux_sel_d = mux_sel_q;
    if (gnt_vld) begin
      mux_sel_d = req_sel[gnt_id*SEL_W +: SEL_W];
`ifdef MUX_ARB_PRIO0_EN
      if (gnt_id != '0) ptr_d = ptr_nxt;
`else
      ptr_d = ptr_nxt;
`endif
    end

    // Tag shift register: new tag enters at stage 0, oldest falls out of the top.
    tag_vld_d = NStg'({tag_vld_q, gnt_vld});
    tag_id_d  = TagW'({tag_id_q, gnt_id});

    // The final tag is consumed on the same edge that samples mux_out.
    rsp_valid_d = tag_vld_q[NStg-1];
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    if (tag_vld_q[NStg-1]) begin
      rsp_id_d   = tag_id_q[TagW-1 -: ID_W];
      rsp_data_d = mux_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      mux_sel_q   <= '0;
      tag_vld_q   <= '0;
      tag_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      mux_sel_q   <= mux_sel_d;
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign mux_sel   = mux_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign idle      = (req == '0) && (tag_vld_q == '0);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: one instance with a combinational mux (MUX_LAT=0) and one with
// a two-stage registered mux (MUX_LAT=2), driven by the same requests. A reference model
// predicts grants from the round-robin rule and schedules each response by grant cycle.

module tb_mux_rr_arbiter;

  localparam int NREQ  = 4;
  localparam int SEL_W = 8;
  localparam int ID_W  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]       req = '0;
  logic [NREQ*SEL_W-1:0] req_sel = '0;
  logic [255:0]          a_in = '0;

  logic [NREQ-1:0]  gnt0, gnt2;
  logic [SEL_W-1:0] mux_sel0, mux_sel2;
  logic             mux_out0, mux_out2;
  logic             rsp_valid0, rsp_valid2, rsp_data0, rsp_data2, idle0, idle2;
  logic [ID_W-1:0]  rsp_id0, rsp_id2;
  logic             m1, m2;

  assign mux_out0 = a_in[mux_sel0];
  always @(posedge clk) begin
    m1 <= a_in[mux_sel2];
    m2 <= m1;
  end
  assign mux_out2 = m2;

  mux_rr_arbiter #(.NREQ(NREQ), .SEL_W(SEL_W), .ID_W(ID_W), .MUX_LAT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(req), .req_sel(req_sel), .gnt(gnt0), .mux_sel(mux_sel0),
    .mux_out(mux_out0), .rsp_valid(rsp_valid0), .rsp_id(rsp_id0), .rsp_data(rsp_data0),
    .idle(idle0)
  );

  mux_rr_arbiter #(.NREQ(NREQ), .SEL_W(SEL_W), .ID_W(ID_W), .MUX_LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req(req), .req_sel(req_sel), .gnt(gnt2), .mux_sel(mux_sel2),
    .mux_out(mux_out2), .rsp_valid(rsp_valid2), .rsp_id(rsp_id2), .rsp_data(rsp_data2),
    .idle(idle2)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state. Index L: 0 -> MUX_LAT=0 instance, 1 -> MUX_LAT=2 instance.
  int              lat_of [2] = '{0, 2};
  bit              sched_v  [2][64];
  logic [ID_W-1:0] sched_id [2][64];
  bit              sched_d  [2][64];
  bit              exp_v    [2];
  logic [ID_W-1:0] exp_id   [2];
  bit              exp_d    [2];
  int              pend     [2];
  logic [7:0]      exp_sel;
  int              ptr_m;
  int              cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] r, input int p);
`ifdef MUX_ARB_PRIO0_EN
    if (r[0]) return 0;
`endif
    for (int i = 0; i < NREQ; i++) begin
      int k;
      k = (p + i) % NREQ;
      if (((r >> k) & 1) != 0) return k;
    end
    return -1;
  endfunction

  task automatic model_clear();
    for (int l = 0; l < 2; l++) begin
      for (int s = 0; s < 64; s++) begin
        sched_v[l][s] = 1'b0;
        sched_id[l][s] = '0;
        sched_d[l][s] = 1'b0;
      end
      exp_v[l] = 1'b0;
      exp_id[l] = '0;
      exp_d[l] = 1'b0;
      pend[l] = 0;
    end
    exp_sel = '0;
    ptr_m = 0;
  endtask

  // Called right after a rising edge with rst_n high.
  task automatic model_edge();
    int k;
    logic [7:0] sel;
    cyc++;
    for (int l = 0; l < 2; l++) begin
      int s;
      s = cyc % 64;
      exp_v[l] = sched_v[l][s];
      if (sched_v[l][s]) begin
        exp_id[l] = sched_id[l][s];
        exp_d[l] = sched_d[l][s];
        sched_v[l][s] = 1'b0;
        pend[l]--;
      end
    end
    k = pick(req, ptr_m);
    if (k >= 0) begin
      sel = 8'(req_sel >> (k * SEL_W));
      exp_sel = sel;
      for (int l = 0; l < 2; l++) begin
        int s;
        s = (cyc + lat_of[l] + 1) % 64;
        sched_v[l][s] = 1'b1;
        sched_id[l][s] = ID_W'(k);
        sched_d[l][s] = a_in[sel];
        pend[l]++;
      end
`ifdef MUX_ARB_PRIO0_EN
      if (k != 0) ptr_m = (k + 1) % NREQ;
`else
      ptr_m = (k + 1) % NREQ;
`endif
    end
  endtask

  task automatic compare_all();
    logic [NREQ-1:0] eg;
    int k;
    eg = '0;
    k = pick(req, ptr_m);
    if (rst_n && k >= 0) eg = NREQ'(1) << k;
    chk("gnt_lat0", 32'(gnt0), 32'(eg));
    chk("gnt_lat2", 32'(gnt2), 32'(eg));
    chk("mux_sel_lat0", 32'(mux_sel0), 32'(exp_sel));
    chk("mux_sel_lat2", 32'(mux_sel2), 32'(exp_sel));
    chk("rsp_valid_lat0", 32'(rsp_valid0), 32'(exp_v[0]));
    chk("rsp_valid_lat2", 32'(rsp_valid2), 32'(exp_v[1]));
    chk("rsp_id_lat0", 32'(rsp_id0), 32'(exp_id[0]));
    chk("rsp_id_lat2", 32'(rsp_id2), 32'(exp_id[1]));
    chk("rsp_data_lat0", 32'(rsp_data0), 32'(exp_d[0]));
    chk("rsp_data_lat2", 32'(rsp_data2), 32'(exp_d[1]));
    if (rst_n || req == '0) begin
      chk("idle_lat0", 32'(idle0), 32'(req == '0 && pend[0] == 0));
      chk("idle_lat2", 32'(idle2), 32'(req == '0 && pend[1] == 0));
    end
  endtask

  // Inputs are already driven (just after a falling edge).
  task automatic tick();
    #2;
    compare_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    #1;
    compare_all();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input int n);
    req = '0;
    repeat (n) tick();
  endtask

  initial begin
    cyc = 0;
    model_clear();
    a_in = {8{$urandom}};

    // Single request from requester 1 at bit 200.
    a_in[200] = 1'b1;
    do_reset();
    req = 4'b0010;
    req_sel = {8'd0, 8'd0, 8'd200, 8'd0};
    tick();
    drain(4);

    // Round-robin rotation with all requesters held high.
    do_reset();
    req = 4'b1111;
    req_sel = {8'd17, 8'd99, 8'd150, 8'd3};
    repeat (8) tick();
    drain(5);

    // Back-to-back grants to indices 0, 63, 64, 255 through the pipelined mux.
    do_reset();
    a_in[0] = 1'b1;
    a_in[63] = 1'b0;
    a_in[64] = 1'b1;
    a_in[255] = 1'b1;
    req_sel = {8'd255, 8'd64, 8'd63, 8'd0};
    req = 4'b1111;
    repeat (4) tick();
    drain(6);

    // Pointer wrap: grant 2 leaves ptr at 3, then 0 must win before 2.
    do_reset();
    req = 4'b0100;
    tick();
    req = 4'b0101;
    tick();
    req = 4'b0100;
    tick();
    drain(5);

    // Reset while requests are in flight in the pipelined mux.
    req = 4'b0001;
    tick();
    req = 4'b1111;
    do_reset();
    drain(6);

    // Requester 0 toggling against a steady 1..3.
    for (int i = 0; i < 12; i++) begin
      req = {3'b111, 1'(i % 2 == 0)};
      req_sel = {$urandom};
      tick();
    end
    drain(5);

    // Random requests and bit indices.
    for (int i = 0; i < 300; i++) begin
      req = NREQ'($urandom_range(0, 15));
      req_sel = {$urandom};
      tick();
    end
    drain(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case a wait never returns.
  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
